// File: rtl/alu_reg_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_reg_ram_pkg
// Description : Shared constants for the alu_reg_ram datapath slice:
//               datapath and address widths, ALU operation codes carried
//               on sel[4:2], and bit positions inside the status flags.
// Revision    : 1.0  initial release
// ============================================================================
package alu_reg_ram_pkg;

    localparam int C_DATA_W     = 64;
    localparam int C_REG_ADDR_W = 5;
    localparam int C_RAM_ADDR_W = 5;

    // Operation field, sel[4:2]. Codes 110 and 111 both pass A'.
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;

    // status = {V, C, N, Z}
    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_C = 2;
    localparam int ST_V = 3;

endpackage : alu_reg_ram_pkg
`default_nettype wire

// File: rtl/alu_reg_ram_alu64.sv
`default_nettype none
// ============================================================================
// Module      : alu64
// Description : Purely combinational ALU with operand inversion and flags.
//   i_a, i_b   : raw operands
//   i_sel      : [0] invert A, [1] invert B, [4:2] operation
//   i_cin      : adder carry-in
//   o_result   : ALU result
//   o_cout     : carry out of the MSB (ADD only, else 0)
//   o_status   : {V, C, N, Z}
// Revision    : 1.0  initial release
// ============================================================================
module alu64
    import alu_reg_ram_pkg::*;
#(
    parameter int DATA_W = C_DATA_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [4:0]        i_sel,
    input  logic              i_cin,
    output logic [DATA_W-1:0] o_result,
    output logic              o_cout,
    output logic [3:0]        o_status
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_sum;
    logic [SH_W-1:0]   w_shamt;
    logic              w_v;

    assign w_a = i_sel[0] ? ~i_a : i_a;
    assign w_b = i_sel[1] ? ~i_b : i_b;

    // One extra bit on the adder captures the carry out of the MSB.
    assign w_sum   = {1'b0, w_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, i_cin};
    // Shift distance comes from the un-inverted B operand.
    assign w_shamt = i_b[SH_W-1:0];

    always_comb begin
        o_result = w_a;
        o_cout   = 1'b0;
        w_v      = 1'b0;
        case (i_sel[4:2])
            OP_AND: o_result = w_a & w_b;
            OP_OR:  o_result = w_a | w_b;
            OP_XOR: o_result = w_a ^ w_b;
            OP_SHL: o_result = w_a << w_shamt;
            OP_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                o_cout   = w_sum[DATA_W];
                // Overflow: like-signed operands producing an opposite sign.
                w_v      = (w_a[DATA_W-1] == w_b[DATA_W-1]) &&
                           (w_sum[DATA_W-1] != w_a[DATA_W-1]);
            end
            OP_SHR: o_result = w_a >> w_shamt;
            default: o_result = w_a;
        endcase
    end

    always_comb begin
        o_status       = 4'b0000;
        o_status[ST_V] = w_v;
        o_status[ST_C] = o_cout;
        o_status[ST_N] = o_result[DATA_W-1];
        o_status[ST_Z] = (o_result == '0);
    end

endmodule : alu64
`default_nettype wire

// File: rtl/alu_reg_ram_regfile32x64.sv
`default_nettype none
// ============================================================================
// Module      : regfile32x64
// Description : Register file, two combinational read ports, one write port.
//               The highest register is hard-wired to zero.
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_we, i_waddr, i_wdata : write port (rising edge)
//   i_raddr_a, o_rdata_a   : read port A
//   i_raddr_b, o_rdata_b   : read port B
// Revision    : 1.0  initial release
// ============================================================================
module regfile32x64
    import alu_reg_ram_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int ADDR_W = C_REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    localparam int                NREGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] C_ZREG = '1;

    logic [DATA_W-1:0] r_regs [0:NREGS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != C_ZREG)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // No write bypass: a same-cycle write becomes visible after the edge.
    assign o_rdata_a = (i_raddr_a == C_ZREG) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == C_ZREG) ? '0 : r_regs[i_raddr_b];

endmodule : regfile32x64
`default_nettype wire

// File: rtl/alu_reg_ram.sv
`default_nettype none
// ============================================================================
// Module      : alu_reg_ram
// Description : Execute/memory slice: register file -> ALU -> data RAM.
//   clock, reset        : clock, asynchronous active-low reset
//   write/writeReg/data : register write port (data also feeds ALU A mux)
//   readA/readB         : register read addresses, values on READA/READB
//   sel/muxSel/cin      : ALU control; A = muxSel ? data : READA
//   aluOut/Cout/status  : ALU result, carry-out, {V,C,N,Z}
//   writeRam/ramOut     : RAM store of READB at aluOut, combinational load
// Revision    : 1.0  initial release
// ============================================================================
module alu_reg_ram
    import alu_reg_ram_pkg::*;
#(
    parameter int DATA_W     = C_DATA_W,
    parameter int REG_ADDR_W = C_REG_ADDR_W,
    parameter int RAM_ADDR_W = C_RAM_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [DATA_W-1:0]     READA,
    output logic [DATA_W-1:0]     READB,
    input  logic                  write,
    input  logic [REG_ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0]     data,
    input  logic [REG_ADDR_W-1:0] readA,
    input  logic [REG_ADDR_W-1:0] readB,
    input  logic [4:0]            sel,
    input  logic                  muxSel,
    input  logic                  cin,
    input  logic                  writeRam,
    output logic [DATA_W-1:0]     ramOut,
    output logic                  Cout,
    output logic [3:0]            status,
    output logic [DATA_W-1:0]     aluOut
);

    localparam int RAM_WORDS = 2 ** RAM_ADDR_W;

    logic [DATA_W-1:0]     w_alu_a;
    logic [RAM_ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0]     r_mem [0:RAM_WORDS-1];

    regfile32x64 #(
        .DATA_W (DATA_W),
        .ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk       (clock),
        .rst_n     (reset),
        .i_we      (write),
        .i_waddr   (writeReg),
        .i_wdata   (data),
        .i_raddr_a (readA),
        .i_raddr_b (readB),
        .o_rdata_a (READA),
        .o_rdata_b (READB)
    );

    assign w_alu_a = muxSel ? data : READA;

    alu64 #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a      (w_alu_a),
        .i_b      (READB),
        .i_sel    (sel),
        .i_cin    (cin),
        .o_result (aluOut),
        .o_cout   (Cout),
        .o_status (status)
    );

    // Word address is the low result bits; upper bits wrap.
    assign w_ram_addr = aluOut[RAM_ADDR_W-1:0];

    // RAM contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (writeRam) begin
            r_mem[w_ram_addr] <= READB;
        end
    end

    assign ramOut = r_mem[w_ram_addr];

endmodule : alu_reg_ram
`default_nettype wire

// File: tb/tb_alu_reg_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_reg_ram
// Description : Directed-vector bench for alu_reg_ram. Stimulus queues the
//               hand-computed expectations; a negedge monitor pops them and
//               compares against the DUT outputs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_reg_ram;

    localparam int K_READA  = 0;
    localparam int K_READB  = 1;
    localparam int K_ALU    = 2;
    localparam int K_STATUS = 3;
    localparam int K_COUT   = 4;
    localparam int K_RAM    = 5;

    typedef struct {
        string       name;
        int          kind;
        logic [63:0] exp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] READA, READB, ramOut, aluOut, data;
    logic        write, muxSel, cin, writeRam, Cout;
    logic [4:0]  writeReg, readA, readB, sel;
    logic [3:0]  status;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    alu_reg_ram dut (
        .clock    (clk),
        .reset    (rst_n),
        .READA    (READA),
        .READB    (READB),
        .write    (write),
        .writeReg (writeReg),
        .data     (data),
        .readA    (readA),
        .readB    (readB),
        .sel      (sel),
        .muxSel   (muxSel),
        .cin      (cin),
        .writeRam (writeRam),
        .ramOut   (ramOut),
        .Cout     (Cout),
        .status   (status),
        .aluOut   (aluOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string n, input int k, input logic [63:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.exp  = v;
        q.push_back(e);
    endtask

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                K_READA:  act = READA;
                K_READB:  act = READB;
                K_ALU:    act = aluOut;
                K_STATUS: act = {60'd0, status};
                K_COUT:   act = {63'd0, Cout};
                default:  act = ramOut;
            endcase
            n_checks++;
            if (act !== e.exp)
                $display("FAIL %s: actual %h required %h", e.name, act, e.exp);
            else
                n_pass++;
        end
    end

    initial begin
        rst_n = 1'b1; write = 0; writeReg = 0; data = 0; readA = 5'd30;
        readB = 5'd29; sel = 5'b10000; muxSel = 0; cin = 0; writeRam = 0;
        #2 rst_n = 1'b0;

        // Reset readback
        step();
        expect_val("rst_reada", K_READA, 64'd0);
        expect_val("rst_readb", K_READB, 64'd0);
        expect_val("rst_alu", K_ALU, 64'd0);
        expect_val("rst_status", K_STATUS, 64'b0001);
        expect_val("rst_cout", K_COUT, 64'd0);
        step(); rst_n = 1'b1;

        // Register writes
        step(); write = 1; writeReg = 5'd29; data = 64'd14;
        expect_val("no_bypass", K_READB, 64'd0);
        step(); writeReg = 5'd30;
        expect_val("wr29_readb", K_READB, 64'd14);
        expect_val("wr30_pending", K_READA, 64'd0);
        step(); write = 0;
        expect_val("wr30_reada", K_READA, 64'd14);
        expect_val("wr_readb", K_READB, 64'd14);
        step(); write = 1; writeReg = 5'd31; data = 64'd99; readA = 5'd31;
        step(); write = 0; data = 64'd0;
        expect_val("r31_zero", K_READA, 64'd0);

        // Add
        step(); readA = 5'd30; sel = 5'b10000; cin = 0;
        expect_val("add_alu", K_ALU, 64'd28);
        expect_val("add_cout", K_COUT, 64'd0);
        expect_val("add_status", K_STATUS, 64'b0000);
        // Subtract
        step(); sel = 5'b10010; cin = 1;
        expect_val("sub_alu", K_ALU, 64'd0);
        expect_val("sub_cout", K_COUT, 64'd1);
        expect_val("sub_status", K_STATUS, 64'b0101);
        // Logic ops, shifts and pass
        step(); sel = 5'b00000; cin = 0;
        expect_val("and_alu", K_ALU, 64'd14);
        step(); sel = 5'b00100;
        expect_val("or_alu", K_ALU, 64'd14);
        step(); sel = 5'b01000;
        expect_val("xor_alu", K_ALU, 64'd0);
        expect_val("xor_status", K_STATUS, 64'b0001);
        step(); sel = 5'b01100;
        expect_val("shl_alu", K_ALU, 64'h0000_0000_0003_8000);
        step(); sel = 5'b11001;
        expect_val("pass_inv_alu", K_ALU, 64'hFFFF_FFFF_FFFF_FFF1);
        expect_val("pass_inv_status", K_STATUS, 64'b0010);
        step(); sel = 5'b10100;
        expect_val("shr_alu", K_ALU, 64'd0);
        expect_val("shr_status", K_STATUS, 64'b0001);
        step(); muxSel = 1; data = 64'h8000_0000_0000_0000;
        expect_val("shr_mux_alu", K_ALU, 64'h0002_0000_0000_0000);
        expect_val("shr_mux_status", K_STATUS, 64'b0000);
        // Overflow and carry
        step(); sel = 5'b10000; cin = 1; readB = 5'd31; data = 64'h7FFF_FFFF_FFFF_FFFF;
        expect_val("ovf_alu", K_ALU, 64'h8000_0000_0000_0000);
        expect_val("ovf_status", K_STATUS, 64'b1010);
        step(); cin = 0; readB = 5'd29; data = 64'hFFFF_FFFF_FFFF_FFFF;
        expect_val("carry_alu", K_ALU, 64'd13);
        expect_val("carry_cout", K_COUT, 64'd1);
        expect_val("carry_status", K_STATUS, 64'b0100);

        // RAM store/load
        step(); muxSel = 0; writeRam = 1;
        expect_val("st_addr", K_ALU, 64'd28);
        step(); writeRam = 0;
        expect_val("ld28", K_RAM, 64'd14);
        step(); write = 1; writeReg = 5'd29; data = 64'd0;
        step(); write = 0;
        expect_val("addr14_alu", K_ALU, 64'd14);
        expect_val("addr14_readb", K_READB, 64'd0);
        step(); muxSel = 1; data = 64'd28;
        expect_val("back28_alu", K_ALU, 64'd28);
        expect_val("back28_ram", K_RAM, 64'd14);
        step(); data = 64'd60;
        expect_val("wrap_ram", K_RAM, 64'd14);
        step(); writeRam = 1;
        expect_val("ram_old_until_edge", K_RAM, 64'd14);
        step(); writeRam = 0;
        expect_val("ram_new", K_RAM, 64'd0);

        // Asynchronous reset mid-cycle
        step(); muxSel = 0; readA = 5'd30; readB = 5'd31; sel = 5'b10000;
        expect_val("pre_areset", K_READA, 64'd14);
        step(); #2 rst_n = 1'b0;
        expect_val("async_reset_reada", K_READA, 64'd0);
        expect_val("async_reset_alu", K_ALU, 64'd0);
        step(); step();

        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: actual %0d pending required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_reg_ram
`default_nettype wire
